// File: rtl/aes_mixcolumns_engine.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_engine
//
// Handshaked MixColumns / InvMixColumns engine for a full 128-bit AES state.
// LANES column units are shared across NB = 4/LANES beats. InvMixColumns is
// computed as a 05/04 pre-multiply followed by the forward MixColumns matrix,
// so each lane carries only one full matrix. A per-transaction bypass passes
// the state through unchanged (final round) with the same latency.
//
// Parameters
//   LANES       column units per beat (1, 2 or 4)
//   DECOMP_REG  1 = register between pre-multiply/mux and MixColumns stage
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    input state available
//   in_ready    engine can accept a state (combinational from out_ready)
//   in_state    column c at [127-32c -: 32], row 0 at MSB of each column
//   in_enc_dec  1 = MixColumns, 0 = InvMixColumns (sampled at accept)
//   in_bypass   1 = pass state through unchanged (sampled at accept)
//   out_valid   result held on out_state
//   out_ready   consumer accepts result
//   out_state   result, same packing as in_state
//   busy        high while processing or holding a result
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// PROC  | issuing beats; leaves after NB + DECOMP_REG cycles
// DONE  | out_valid high, out_state frozen until out_ready
// ---------------------------------------------------------------------------
module aes_mixcolumns_engine #(
    parameter int LANES      = 1,
    parameter int DECOMP_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_enc_dec,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NB = 4 / LANES;
    localparam int N  = NB + DECOMP_REG;
    localparam int CW = 3;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("aes_mixcolumns_engine: LANES must be 1, 2 or 4");
        end
        if (!(DECOMP_REG == 0 || DECOMP_REG == 1)) begin : g_bad_decomp
            $error("aes_mixcolumns_engine: DECOMP_REG must be 0 or 1");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11B
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_mix(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        r0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        r3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
        return {r0, r1, r2, r3};
    endfunction

    // 05/04 pre-multiply: fwd_mix(inv_pre(a)) == InvMixColumns(a)
    function automatic logic [31:0] inv_pre(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] q0, q1, q2, q3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        q0 = xtime(xtime(a0));
        q1 = xtime(xtime(a1));
        q2 = xtime(xtime(a2));
        q3 = xtime(xtime(a3));
        return {q0 ^ a0 ^ q2,
                q1 ^ a1 ^ q3,
                q0 ^ q2 ^ a2,
                q1 ^ q3 ^ a3};
    endfunction

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    src_q, src_d;
    logic [127:0]    res_q, res_d;
    logic            enc_q, enc_d;
    logic            byp_q, byp_d;
    logic            accept;

    // -----------------------------------------------------------------------
    // Lane datapath
    // -----------------------------------------------------------------------
    logic [31:0]     src_col [4];
    logic [31:0]     lane_a  [LANES];
    logic [31:0]     lane_d  [LANES];
    logic [31:0]     mix_in  [LANES];
    logic [31:0]     lane_r  [LANES];
    logic            issue;
    logic [CW-1:0]   beat_idx;
    logic            wr_en;
    logic [CW-1:0]   wr_beat;

    // With DECOMP_REG the counter runs one past the last beat to drain the
    // pipe register; beat_idx is forced to 0 then so column selects stay
    // in range.
    assign issue    = (state_q == S_PROC) && (cnt_q < CW'(NB));
    assign beat_idx = issue ? cnt_q : '0;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            src_col[c] = src_q[127 - 32*c -: 32];
        end
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = src_col[2'(int'(beat_idx) * LANES + l)];
            lane_d[l] = (enc_q || byp_q) ? lane_a[l] : inv_pre(lane_a[l]);
        end
    end

    generate
        if (DECOMP_REG == 1) begin : g_pipe
            logic [31:0]   pipe_q [LANES];
            logic          pipe_vld_q;
            logic [CW-1:0] pipe_beat_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe_vld_q  <= 1'b0;
                    pipe_beat_q <= '0;
                    for (int l = 0; l < LANES; l++) begin
                        pipe_q[l] <= '0;
                    end
                end else begin
                    pipe_vld_q  <= issue;
                    pipe_beat_q <= beat_idx;
                    if (issue) begin
                        for (int l = 0; l < LANES; l++) begin
                            pipe_q[l] <= lane_d[l];
                        end
                    end
                end
            end

            always_comb begin
                for (int l = 0; l < LANES; l++) begin
                    mix_in[l] = pipe_q[l];
                end
            end

            assign wr_en   = pipe_vld_q;
            assign wr_beat = pipe_beat_q;
        end else begin : g_nopipe
            always_comb begin
                for (int l = 0; l < LANES; l++) begin
                    mix_in[l] = lane_d[l];
                end
            end

            assign wr_en   = issue;
            assign wr_beat = beat_idx;
        end
    endgenerate

    // byp_q/enc_q are stable for the whole transaction: a new accept can
    // only happen in DONE, after the pipe register has drained.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_r[l] = byp_q ? mix_in[l] : fwd_mix(mix_in[l]);
        end
    end

    always_comb begin
        res_d = res_q;
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                res_d[127 - 32*(int'(wr_beat) * LANES + l) -: 32] = lane_r[l];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    assign in_ready = rst_n && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        enc_d   = enc_q;
        byp_d   = byp_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_PROC: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Covers both the IDLE accept and the back-to-back accept in DONE.
        if (accept) begin
            state_d = S_PROC;
            cnt_d   = '0;
            src_d   = in_state;
            enc_d   = in_enc_dec;
            byp_d   = in_bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            enc_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            enc_q   <= enc_d;
            byp_q   <= byp_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_state = res_q;

endmodule

// File: tb/tb_aes_mixcolumns_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_mixcolumns_engine
//
// Instantiates the engine in all six LANES/DECOMP_REG combinations, each with
// its own driver and scoreboard monitor. Drivers push expected results and
// accept cycles into per-instance queues; monitors pop and compare whenever
// the engine presents a result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_mixcolumns_engine;

    localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_AE = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_B  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V_BE = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V_P  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V_C6 = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] V_D4 = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] V_D5 = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit done_flags [6];

    task automatic chk(input int cfg, input string name,
                       input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL cfg%0d %s: got %h expected %h", cfg, name, act, req);
    endtask

    task automatic chk1(input int cfg, input string name, input logic act, input logic req);
        chk(cfg, name, {127'b0, act}, {127'b0, req});
    endtask

    // Golden model: generic GF multiply with the full FIPS-197 matrices.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit enc);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   r;
        logic [127:0] o;
        if (enc) base = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(base[(j - i + 4) % 4], a[j]);
                o[127 - 32*c - 8*i -: 8] = r;
            end
        end
        return o;
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int L  = (g < 2) ? 1 : (g < 4) ? 2 : 4;
        localparam int D  = g % 2;
        localparam int TN = 4 / L + D;

        logic         rst_n, in_valid, in_ready, in_enc_dec, in_bypass;
        logic         out_valid, out_ready, busy;
        logic [127:0] in_state, out_state;
        bit           rand_rdy = 1'b0;
        logic [127:0] exp_q [$];
        int           acc_q [$];

        aes_mixcolumns_engine #(.LANES(L), .DECOMP_REG(D)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_state   (in_state),
            .in_enc_dec (in_enc_dec),
            .in_bypass  (in_bypass),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_state  (out_state),
            .busy       (busy)
        );

        task automatic send(input logic [127:0] s, input bit enc, input bit byp,
                            input logic [127:0] expv, input bit track);
            int w;
            in_state   = s;
            in_enc_dec = enc;
            in_bypass  = byp;
            in_valid   = 1'b1;
            w = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (in_ready !== 1'b1) begin
                chk1(g, "accept_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
            end else begin
                if (track) begin
                    exp_q.push_back(expv);
                    acc_q.push_back(cyc + 1);
                end
                @(posedge clk);
                #1;
                // Scramble inputs after accept; the in-flight state must not see it.
                in_valid   = 1'b0;
                in_state   = ~s;
                in_enc_dec = !enc;
                in_bypass  = !byp;
            end
        endtask

        task automatic drain();
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk(g, "drain", 128'(exp_q.size()), 128'(0));
        endtask

        initial forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
        end

        initial begin : mon
            bit ov_prev;
            ov_prev = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    ov_prev = 1'b0;
                end else begin
                    if (out_valid && !ov_prev) begin
                        if (acc_q.size() == 0) chk1(g, "unexpected_out_valid", out_valid, 1'b0);
                        else chk(g, "latency", 128'(cyc - acc_q.pop_front()), 128'(TN));
                    end
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            chk1(g, "unexpected_result", out_valid, 1'b0);
                        end else begin
                            chk(g, "out_state", out_state, exp_q[0]);
                            chk1(g, "in_ready_done", in_ready, out_ready);
                            if (out_ready) void'(exp_q.pop_front());
                        end
                    end
                    ov_prev = out_valid;
                end
            end
        end

        initial begin : drv
            logic [127:0] x, y;
            int c0, k, w;
            rst_n      = 1'b0;
            in_valid   = 1'b0;
            in_state   = '0;
            in_enc_dec = 1'b0;
            in_bypass  = 1'b0;
            out_ready  = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk1(g, "rst_out_valid", out_valid, 1'b0);
            chk (g, "rst_out_state", out_state, '0);
            chk1(g, "rst_busy", busy, 1'b0);
            chk1(g, "rst_in_ready_low", in_ready, 1'b0);
            rst_n = 1'b1;
            @(negedge clk);
            chk1(g, "rst_in_ready_release", in_ready, 1'b1);
            @(posedge clk);
            #1;

            // Directed vectors, issued back to back
            send(V_A,  1'b1, 1'b0, V_AE, 1'b1);
            send(V_AE, 1'b0, 1'b0, V_A,  1'b1);
            send(V_P,  1'b1, 1'b1, V_P,  1'b1);
            send(V_B,  1'b1, 1'b0, V_BE, 1'b1);
            send(V_BE, 1'b0, 1'b0, V_B,  1'b1);
            send(V_B,  1'b0, 1'b1, V_B,  1'b1);
            drain();

            // Backpressure, then release together with a new input
            out_ready = 1'b0;
            send(V_A, 1'b1, 1'b0, V_AE, 1'b1);
            w = 0;
            while (out_valid !== 1'b1 && w < 50) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk1(g, "bp_out_valid", out_valid, 1'b1);
            repeat (5) begin
                @(posedge clk);
                #1;
            end
            c0 = cyc;
            out_ready = 1'b1;
            send(V_C6, 1'b1, 1'b0, V_C6, 1'b1);
            chk(g, "b2b_same_cycle", 128'(cyc), 128'(c0 + 1));
            drain();

            // Reset in the middle of PROC
            k = (TN - 1 < 2) ? TN - 1 : 2;
            send(V_A, 1'b1, 1'b0, '0, 1'b0);
            repeat (k) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(negedge clk);
            chk1(g, "midrst_in_ready", in_ready, 1'b0);
            chk1(g, "midrst_busy_before", busy, 1'b1);
            @(posedge clk);
            #1;
            chk1(g, "midrst_out_valid", out_valid, 1'b0);
            chk (g, "midrst_out_state", out_state, '0);
            chk1(g, "midrst_busy", busy, 1'b0);
            rst_n = 1'b1;
            @(negedge clk);
            chk1(g, "midrst_in_ready_release", in_ready, 1'b1);
            @(posedge clk);
            #1;
            send(V_D4, 1'b1, 1'b0, V_D5, 1'b1);
            drain();

            // Random round trips against the golden model
            rand_rdy = 1'b1;
            for (int i = 0; i < 84; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                y = mix_model(x, 1'b1);
                send(x, 1'b1, 1'b0, y, 1'b1);
                send(y, 1'b0, 1'b0, x, 1'b1);
                if (i % 8 == 0) send(x, ((i / 8) % 2) == 1, 1'b1, x, 1'b1);
            end
            rand_rdy  = 1'b0;
            out_ready = 1'b1;
            drain();
            done_flags[g] = 1'b1;
        end
    end

    initial begin : main
        int  w;
        bit  all;
        w   = 0;
        all = 1'b0;
        while (!all && w < 40000) begin
            @(posedge clk);
            all = 1'b1;
            for (int i = 0; i < 6; i++) if (!done_flags[i]) all = 1'b0;
            w++;
        end
        if (!all) begin
            n_total++;
            $display("FAIL global_timeout: got unfinished instances after %0d cycles expected all done", w);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
